// File: rtl/tohost_responder.sv
// tohost_responder
//   Test-harness responder for the tohost/fromhost handshake that test
//   programs use to report completion and print console characters.
//
//   Ports (names follow the harness bus):
//     clock, reset            clock; asynchronous active-low reset
//     aw_* / w_* / b_*        64-bit AXI4-Lite-style write channels
//     ar_* / r_*              64-bit AXI4-Lite-style read channels
//     char_valid/ready/data   console byte handshake
//     success, failure        sticky completion flags (mutually exclusive)
//     exit_code               code[31:0] taken from the first exit command
//
//   Write FSM
//     state  | meaning
//     W_IDLE | collecting AW and W beats (either order, or together)
//     W_EXEC | one-cycle decode/execute of the captured write
//     W_CHAR | presenting a console byte, waiting for char_ready
//     W_RESP | holding b_valid/b_resp until b_ready
//   Read FSM
//     state  | meaning
//     R_IDLE | ar_ready high, waiting for a read address
//     R_RESP | holding r_valid/r_data/r_resp until r_ready
module tohost_responder #(
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR   = 32'h8000_1000,
    parameter logic [ADDR_W-1:0] FROMHOST_ADDR = 32'h8000_1040
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [63:0]       w_data,
    input  logic [7:0]        w_strb,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [1:0]        b_resp,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [ADDR_W-1:0] ar_addr,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [63:0]       r_data,
    output logic [1:0]        r_resp,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [7:0]        char_data,
    output logic              success,
    output logic              failure,
    output logic [31:0]       exit_code
);

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [63:0] FROMHOST_ACK = 64'h0101_0000_0000_0001;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_CHAR, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_RESP} rstate_t;

    wstate_t           wstate_q, wstate_d;
    rstate_t           rstate_q, rstate_d;
    logic              aw_got_q, aw_got_d;
    logic              w_got_q, w_got_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [7:0]        wstrb_q, wstrb_d;
    logic [63:0]       tohost_q, tohost_d;
    logic [63:0]       fromhost_q, fromhost_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [7:0]        chardata_q, chardata_d;
    logic              success_q, success_d;
    logic              failure_q, failure_d;
    logic [31:0]       exitcode_q, exitcode_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic is_to, is_from, flag_set;

    assign is_to    = (awaddr_q == TOHOST_ADDR);
    assign is_from  = (awaddr_q == FROMHOST_ADDR);
    assign flag_set = success_q | failure_q;

    always_comb begin
        wstate_d   = wstate_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        tohost_d   = tohost_q;
        fromhost_d = fromhost_q;
        bresp_d    = bresp_q;
        chardata_d = chardata_q;
        success_d  = success_q;
        failure_d  = failure_q;
        exitcode_d = exitcode_q;
        unique case (wstate_q)
            W_IDLE: begin
                if (aw_valid && !aw_got_q) begin
                    aw_got_d = 1'b1;
                    awaddr_d = aw_addr;
                end
                if (w_valid && !w_got_q) begin
                    w_got_d = 1'b1;
                    wdata_d = w_data;
                    wstrb_d = w_strb;
                end
                if (aw_got_d && w_got_d) wstate_d = W_EXEC;
            end
            W_EXEC: begin
                aw_got_d = 1'b0;
                w_got_d  = 1'b0;
                bresp_d  = RESP_OKAY;
                wstate_d = W_RESP;
                if (!is_to && !is_from) begin
                    bresp_d = RESP_DECERR;
                end else if (wstrb_q != 8'hFF) begin
                    bresp_d = RESP_SLVERR;
                end else if (is_from) begin
                    fromhost_d = wdata_q;
                end else if (wdata_q == 64'd0) begin
                    // tohost cleared by the program: nothing to do
                end else if (wdata_q[63:56] == 8'd1 && wdata_q[55:48] == 8'd1) begin
                    // Putchar is tested before exit: printable bytes may have bit 0 set.
                    tohost_d   = wdata_q;
                    chardata_d = wdata_q[7:0];
                    wstate_d   = W_CHAR;
                end else if (wdata_q[0]) begin
                    if (!flag_set) begin
                        exitcode_d = wdata_q[32:1];
                        success_d  = (wdata_q[63:1] == 63'd0);
                        failure_d  = (wdata_q[63:1] != 63'd0);
                    end
                end else if (!flag_set) begin
                    failure_d  = 1'b1;
                    exitcode_d = 32'hFFFF_FFFF;
                end
            end
            W_CHAR: begin
                if (char_ready) begin
                    tohost_d   = 64'd0;
                    fromhost_d = FROMHOST_ACK;
                    wstate_d   = W_RESP;
                end
            end
            W_RESP: begin
                if (b_ready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (ar_valid) begin
                    rstate_d = R_RESP;
                    if (ar_addr == TOHOST_ADDR) begin
                        rdata_d = tohost_q;
                        rresp_d = RESP_OKAY;
                    end else if (ar_addr == FROMHOST_ADDR) begin
                        rdata_d = fromhost_q;
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = 64'd0;
                        rresp_d = RESP_DECERR;
                    end
                end
            end
            R_RESP: begin
                if (r_ready) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wstate_q   <= W_IDLE;
            rstate_q   <= R_IDLE;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= 64'd0;
            wstrb_q    <= 8'd0;
            tohost_q   <= 64'd0;
            fromhost_q <= 64'd0;
            bresp_q    <= 2'd0;
            chardata_q <= 8'd0;
            success_q  <= 1'b0;
            failure_q  <= 1'b0;
            exitcode_q <= 32'd0;
            rdata_q    <= 64'd0;
            rresp_q    <= 2'd0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            tohost_q   <= tohost_d;
            fromhost_q <= fromhost_d;
            bresp_q    <= bresp_d;
            chardata_q <= chardata_d;
            success_q  <= success_d;
            failure_q  <= failure_d;
            exitcode_q <= exitcode_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign aw_ready   = (wstate_q == W_IDLE) && !aw_got_q;
    assign w_ready    = (wstate_q == W_IDLE) && !w_got_q;
    assign b_valid    = (wstate_q == W_RESP);
    assign b_resp     = bresp_q;
    assign char_valid = (wstate_q == W_CHAR);
    assign char_data  = chardata_q;
    assign ar_ready   = (rstate_q == R_IDLE);
    assign r_valid    = (rstate_q == R_RESP);
    assign r_data     = rdata_q;
    assign r_resp     = rresp_q;
    assign success    = success_q;
    assign failure    = failure_q;
    assign exit_code  = exitcode_q;

endmodule

// File: tb/tb_tohost_responder.sv
module tb_tohost_responder;

    localparam logic [31:0] TO   = 32'h8000_1000;
    localparam logic [31:0] FROM = 32'h8000_1040;
    localparam logic [31:0] BAD  = 32'h8000_2000;
    localparam int          TMO  = 50;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        aw_valid = 1'b0, aw_ready;
    logic [31:0] aw_addr = '0;
    logic        w_valid = 1'b0, w_ready;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        b_valid, b_ready = 1'b0;
    logic [1:0]  b_resp;
    logic        ar_valid = 1'b0, ar_ready;
    logic [31:0] ar_addr = '0;
    logic        r_valid, r_ready = 1'b0;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        char_valid, char_ready = 1'b0;
    logic [7:0]  char_data;
    logic        success, failure;
    logic [31:0] exit_code;

    int checks = 0;
    int failures = 0;

    logic [1:0]  bq[$];
    logic [65:0] rq[$];

    always #5 clock = ~clock;

    tohost_responder dut (
        .clock(clock), .reset(reset),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
        .success(success), .failure(failure), .exit_code(exit_code)
    );

    task automatic do_reset();
        aw_valid = 0; w_valid = 0; ar_valid = 0; b_ready = 0; r_ready = 0; char_ready = 0;
        @(negedge clock);
        reset = 0;
        repeat (2) @(negedge clock);
        reset = 1;
        @(negedge clock);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d,
                            input logic [7:0] s, input logic [1:0] exp);
        int n = 0;
        bq.push_back(exp);
        aw_valid = 1; aw_addr = a; w_valid = 1; w_data = d; w_strb = s;
        while (!(aw_ready && w_ready) && n < TMO) begin @(negedge clock); n++; end
        checks++;
        if (!(aw_ready && w_ready)) begin
            failures++;
            $display("FAIL write_accept aw_ready=%0b w_ready=%0b required=1", aw_ready, w_ready);
        end
        @(negedge clock);
        aw_valid = 0; w_valid = 0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s);
        int n = 0;
        w_valid = 1; w_data = d; w_strb = s;
        while (!w_ready && n < TMO) begin @(negedge clock); n++; end
        checks++;
        if (!w_ready) begin failures++; $display("FAIL w_accept w_ready=%0b required=1", w_ready); end
        @(negedge clock);
        w_valid = 0;
    endtask

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        aw_valid = 1; aw_addr = a;
        while (!aw_ready && n < TMO) begin @(negedge clock); n++; end
        checks++;
        if (!aw_ready) begin failures++; $display("FAIL aw_accept aw_ready=%0b required=1", aw_ready); end
        @(negedge clock);
        aw_valid = 0;
    endtask

    task automatic get_b();
        int n = 0;
        logic [1:0] exp;
        while (!b_valid && n < TMO) begin @(negedge clock); n++; end
        exp = (bq.size() > 0) ? bq.pop_front() : 2'b01;
        checks++;
        if (!b_valid || b_resp !== exp) begin
            failures++;
            $display("FAIL b_resp b_valid=%0b got=%b required=%b", b_valid, b_resp, exp);
        end
        b_ready = 1;
        @(negedge clock);
        b_ready = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [63:0] d, input logic [1:0] rs);
        int n = 0;
        logic [65:0] exp;
        rq.push_back({rs, d});
        ar_valid = 1; ar_addr = a;
        while (!ar_ready && n < TMO) begin @(negedge clock); n++; end
        @(negedge clock);
        ar_valid = 0;
        n = 0;
        while (!r_valid && n < TMO) begin @(negedge clock); n++; end
        exp = rq.pop_front();
        checks++;
        if (!r_valid || {r_resp, r_data} !== exp) begin
            failures++;
            $display("FAIL read %h r_valid=%0b got=%b/%h required=%b/%h",
                     a, r_valid, r_resp, r_data, exp[65:64], exp[63:0]);
        end
        r_ready = 1;
        @(negedge clock);
        r_ready = 0;
    endtask

    task automatic check_flags(input string nm, input logic s, input logic f, input logic [31:0] c);
        checks++;
        if (success !== s || failure !== f || exit_code !== c) begin
            failures++;
            $display("FAIL %s got s=%0b f=%0b code=%h required s=%0b f=%0b code=%h",
                     nm, success, failure, exit_code, s, f, c);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b111 ||
            {b_valid, r_valid, char_valid} !== 3'b000 ||
            b_resp !== 2'b00 || r_resp !== 2'b00 || r_data !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs rdy=%b vld=%b bresp=%b rresp=%b rdata=%h required 111/000/0/0/0",
                     {aw_ready, w_ready, ar_ready}, {b_valid, r_valid, char_valid}, b_resp, r_resp, r_data);
        end
        check_flags("reset_flags", 0, 0, 32'd0);
        do_reset();
        do_read(TO, 64'd0, 2'b00);
        do_read(FROM, 64'd0, 2'b00);
    endtask

    task automatic test_exit_success();
        do_reset();
        do_write(TO, 64'h1, 8'hFF, 2'b00);
        checks++;
        if (success !== 1'b0 || b_valid !== 1'b0) begin
            failures++;
            $display("FAIL exec_cycle success=%0b b_valid=%0b required 0/0", success, b_valid);
        end
        @(negedge clock);
        check_flags("exit0_flags", 1, 0, 32'd0);
        get_b();
        do_read(TO, 64'd0, 2'b00);
    endtask

    task automatic test_exit_fail();
        do_reset();
        do_write(TO, 64'h7, 8'hFF, 2'b00);
        get_b();
        check_flags("exit3_flags", 0, 1, 32'd3);
        do_write(TO, 64'h1, 8'hFF, 2'b00);
        get_b();
        check_flags("exit_sticky", 0, 1, 32'd3);
        do_reset();
        do_write(TO, 64'h2, 8'hFF, 2'b00);
        get_b();
        check_flags("bad_cmd", 0, 1, 32'hFFFF_FFFF);
    endtask

    task automatic test_putchar();
        do_reset();
        char_ready = 0;
        do_write(TO, 64'h0101_0000_0000_0041, 8'hFF, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (char_valid !== 1'b1 || char_data !== 8'h41 || b_valid !== 1'b0) begin
                failures++;
                $display("FAIL char_hold cyc=%0d cv=%0b cd=%h bv=%0b required 1/41/0",
                         i, char_valid, char_data, b_valid);
            end
        end
        char_ready = 1;
        @(negedge clock);
        char_ready = 0;
        get_b();
        check_flags("putchar_flags", 0, 0, 32'd0);
        do_read(TO, 64'd0, 2'b00);
        do_read(FROM, 64'h0101_0000_0000_0001, 2'b00);
    endtask

    task automatic test_w_before_aw();
        int n = 0;
        logic [1:0] held;
        do_reset();
        send_w(64'hDEAD_BEEF_0123_4567, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (w_ready !== 1'b0 || aw_ready !== 1'b1 || b_valid !== 1'b0) begin
                failures++;
                $display("FAIL w_first_wait w_ready=%0b aw_ready=%0b b_valid=%0b required 0/1/0",
                         w_ready, aw_ready, b_valid);
            end
            if (i < 2) @(negedge clock);
        end
        bq.push_back(2'b00);
        send_aw(FROM);
        while (!b_valid && n < TMO) begin @(negedge clock); n++; end
        held = b_resp;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (b_valid !== 1'b1 || b_resp !== held) begin
                failures++;
                $display("FAIL b_stall b_valid=%0b b_resp=%b required 1/%b", b_valid, b_resp, held);
            end
        end
        get_b();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (b_valid !== 1'b0) begin
                failures++;
                $display("FAIL b_single b_valid=%0b required 0", b_valid);
            end
            @(negedge clock);
        end
        do_read(FROM, 64'hDEAD_BEEF_0123_4567, 2'b00);
    endtask

    task automatic test_errors();
        do_reset();
        do_write(BAD, 64'h1, 8'hFF, 2'b11);
        get_b();
        do_write(TO, 64'h1, 8'h0F, 2'b10);
        get_b();
        do_write(FROM, 64'h55, 8'h0F, 2'b10);
        get_b();
        do_read(BAD, 64'd0, 2'b11);
        do_read(FROM, 64'd0, 2'b00);
        check_flags("err_no_flags", 0, 0, 32'd0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_write(TO, 64'h1, 8'hFF, 2'b00);
        get_b();
        char_ready = 0;
        do_write(TO, 64'h0101_0000_0000_0042, 8'hFF, 2'b00);
        repeat (2) @(negedge clock);
        checks++;
        if (char_valid !== 1'b1 || success !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset char_valid=%0b success=%0b required 1/1", char_valid, success);
        end
        #2 reset = 0;
        #1;
        checks++;
        if ({char_valid, b_valid, success, failure} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset cv/bv/s/f=%b required 0000", {char_valid, b_valid, success, failure});
        end
        bq.delete();
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        checks++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin
            failures++;
            $display("FAIL post_reset_ready got=%b required 111", {aw_ready, w_ready, ar_ready});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if ({char_valid, b_valid, r_valid} !== 3'b000) begin
                failures++;
                $display("FAIL abandoned cv/bv/rv=%b required 000", {char_valid, b_valid, r_valid});
            end
        end
        do_read(TO, 64'd0, 2'b00);
    endtask

    initial begin
        test_reset();
        test_exit_success();
        test_exit_fail();
        test_putchar();
        test_w_before_aw();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
